// File: rtl/gpio_pkg.sv
// Shared constants and types for the GPIO register front end.
package gpio_pkg;

  localparam int GPIO_DEFAULT_WIDTH = 32;

  // Byte offsets of the register window.
  localparam int GPIO_DIR_OFS = 'h00;
  localparam int GPIO_OUT_OFS = 'h04;
  localparam int GPIO_SET_OFS = 'h08;
  localparam int GPIO_CLR_OFS = 'h0C;
  localparam int GPIO_IN_OFS  = 'h10;

  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } bus_state_t;

endpackage

// File: rtl/gpio_sync.sv
// Multi-flop synchroniser for the raw GPIO input pins; STAGES must be >= 2.
module gpio_sync #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] pins,
  output logic [WIDTH-1:0] synced
);

  logic [WIDTH-1:0] chain [STAGES];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < STAGES; i++) chain[i] <= '0;
    end else begin
      chain[0] <= pins;
      for (int i = 1; i < STAGES; i++) chain[i] <= chain[i-1];
    end
  end

  assign synced = chain[STAGES-1];

endmodule

// File: rtl/gpio_reg_if.sv
// Bus-slave register front end driving the GPIO output stage.
// Optional macro GPIO_BYTE_STROBE_EN enables per-byte write strobes via be_i.
module gpio_reg_if
  import gpio_pkg::*;
#(
  parameter int GPIO_WIDTH  = GPIO_DEFAULT_WIDTH,
  parameter int ADDR_W      = 5,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req_i,
  output logic                  ready_o,
  input  logic                  we_i,
  input  logic [ADDR_W-1:0]     addr_i,
  input  logic [31:0]           wdata_i,
  input  logic [3:0]            be_i,
  output logic                  resp_valid_o,
  input  logic                  resp_ready_i,
  output logic [31:0]           rdata_o,
  output logic                  err_o,
  input  logic [GPIO_WIDTH-1:0] gpio_input_i,
  output logic [GPIO_WIDTH-1:0] gpio_direction_o,
  output logic [GPIO_WIDTH-1:0] gpio_output_o,
  output logic [GPIO_WIDTH-1:0] gpio_output_set_o,
  output logic [GPIO_WIDTH-1:0] gpio_output_clr_o
);

  // Handshake: a request is accepted on the edge where req_i & ready_o;
  // the response is retired on the edge where resp_valid_o & resp_ready_i.
  // ready_o and resp_valid_o are mutually exclusive, so one access at a time.

  bus_state_t            state;
  logic [GPIO_WIDTH-1:0] pins_synced;
  logic [ADDR_W-1:0]     word_addr;
  logic                  sel_dir, sel_out, sel_set, sel_clr, sel_in, mapped;
  logic                  wr_err, rd_err;
  logic [GPIO_WIDTH-1:0] wd, mask, wd_m, rd_val;
  logic                  unused_bits;

  gpio_sync #(
    .WIDTH  (GPIO_WIDTH),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .pins   (gpio_input_i),
    .synced (pins_synced)
  );

  assign word_addr = {addr_i[ADDR_W-1:2], 2'b00};
  assign sel_dir   = (word_addr == ADDR_W'(GPIO_DIR_OFS));
  assign sel_out   = (word_addr == ADDR_W'(GPIO_OUT_OFS));
  assign sel_set   = (word_addr == ADDR_W'(GPIO_SET_OFS));
  assign sel_clr   = (word_addr == ADDR_W'(GPIO_CLR_OFS));
  assign sel_in    = (word_addr == ADDR_W'(GPIO_IN_OFS));
  assign mapped    = sel_dir | sel_out | sel_set | sel_clr | sel_in;
  assign wr_err    = sel_in | ~mapped;
  assign rd_err    = ~mapped;

  assign wd = wdata_i[GPIO_WIDTH-1:0];

`ifdef GPIO_BYTE_STROBE_EN
  always_comb begin
    mask = '0;
    for (int i = 0; i < GPIO_WIDTH; i++) mask[i] = be_i[i/8];
  end
  assign unused_bits = ^addr_i[1:0];
`else
  assign mask        = '1;
  assign unused_bits = ^{addr_i[1:0], be_i};
`endif

  assign wd_m = wd & mask;

  // SET and CLR are write-only and read back as zero without error.
  always_comb begin
    rd_val = '0;
    if (sel_dir)     rd_val = gpio_direction_o;
    else if (sel_out) rd_val = gpio_output_o;
    else if (sel_in)  rd_val = pins_synced;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state             <= IDLE;
      ready_o           <= 1'b1;
      resp_valid_o      <= 1'b0;
      rdata_o           <= '0;
      err_o             <= 1'b0;
      gpio_direction_o  <= '0;
      gpio_output_o     <= '0;
      gpio_output_set_o <= '0;
      gpio_output_clr_o <= '0;
    end else begin
      gpio_output_set_o <= '0;
      gpio_output_clr_o <= '0;
      case (state)
        IDLE: begin
          if (req_i) begin
            state        <= RESP;
            ready_o      <= 1'b0;
            resp_valid_o <= 1'b1;
            err_o        <= we_i ? wr_err : rd_err;
            rdata_o      <= we_i ? 32'd0 : 32'(rd_val);
            if (we_i && !wr_err) begin
              if (sel_dir) gpio_direction_o <= (gpio_direction_o & ~mask) | wd_m;
              if (sel_out) gpio_output_o    <= (gpio_output_o & ~mask) | wd_m;
              if (sel_set) begin
                gpio_output_o     <= gpio_output_o | wd_m;
                gpio_output_set_o <= wd_m;
              end
              if (sel_clr) begin
                gpio_output_o     <= gpio_output_o & ~wd_m;
                gpio_output_clr_o <= wd_m;
              end
            end
          end
        end
        RESP: begin
          if (resp_ready_i) begin
            state        <= IDLE;
            ready_o      <= 1'b1;
            resp_valid_o <= 1'b0;
          end
        end
        default: begin
          state        <= IDLE;
          ready_o      <= 1'b1;
          resp_valid_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gpio_reg_if.sv
// Directed vector bench for gpio_reg_if: register table plus multi-cycle corner sequences.
module tb_gpio_reg_if;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic [4:0]  addr = '0;
  logic [31:0] wdata = '0;
  logic [3:0]  be = 4'hF;
  logic        resp_ready = 1'b0;
  logic [31:0] gpio_in = '0;
  logic        ready, resp_valid, err;
  logic [31:0] rdata, dir, out, set_p, clr_p;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  gpio_reg_if dut (
    .clk_i             (clk),
    .rst_i             (rst),
    .req_i             (req),
    .ready_o           (ready),
    .we_i              (we),
    .addr_i            (addr),
    .wdata_i           (wdata),
    .be_i              (be),
    .resp_valid_o      (resp_valid),
    .resp_ready_i      (resp_ready),
    .rdata_o           (rdata),
    .err_o             (err),
    .gpio_input_i      (gpio_in),
    .gpio_direction_o  (dir),
    .gpio_output_o     (out),
    .gpio_output_set_o (set_p),
    .gpio_output_clr_o (clr_p)
  );

  typedef struct {
    logic        we;
    logic [4:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    logic [31:0] exp_dir;
    logic [31:0] exp_out;
  } vec_t;

  vec_t vecs [14];

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endfunction

  // Drive a request and return 1 time unit after its accept edge.
  task automatic issue(input logic w, input logic [4:0] a, input logic [31:0] d, input logic [3:0] b);
    int n = 0;
    req = 1'b1; we = w; addr = a; wdata = d; be = b;
    while (!ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("ready_before_accept", {31'd0, ready}, 32'd1);
    @(posedge clk);
    #1;
    req = 1'b0;
  endtask

  task automatic finish_resp();
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    resp_ready = 1'b0;
  endtask

  initial begin
    vecs[0]  = '{1'b1, 5'h04, 32'hA5A5_0F0F, 32'h0, 1'b0, 32'h0,      32'hA5A5_0F0F};
    vecs[1]  = '{1'b0, 5'h04, 32'h0,         32'hA5A5_0F0F, 1'b0, 32'h0, 32'hA5A5_0F0F};
    vecs[2]  = '{1'b1, 5'h00, 32'h0000_FFFF, 32'h0, 1'b0, 32'hFFFF, 32'hA5A5_0F0F};
    vecs[3]  = '{1'b0, 5'h00, 32'h0,         32'hFFFF, 1'b0, 32'hFFFF, 32'hA5A5_0F0F};
    vecs[4]  = '{1'b1, 5'h08, 32'h0F00_0000, 32'h0, 1'b0, 32'hFFFF, 32'hAFA5_0F0F};
    vecs[5]  = '{1'b1, 5'h0C, 32'hA5A5_0000, 32'h0, 1'b0, 32'hFFFF, 32'h0A00_0F0F};
    vecs[6]  = '{1'b0, 5'h08, 32'h0,         32'h0, 1'b0, 32'hFFFF, 32'h0A00_0F0F};
    vecs[7]  = '{1'b0, 5'h0C, 32'h0,         32'h0, 1'b0, 32'hFFFF, 32'h0A00_0F0F};
    vecs[8]  = '{1'b1, 5'h10, 32'hFFFF_FFFF, 32'h0, 1'b1, 32'hFFFF, 32'h0A00_0F0F};
    vecs[9]  = '{1'b1, 5'h1C, 32'h1234_5678, 32'h0, 1'b1, 32'hFFFF, 32'h0A00_0F0F};
    vecs[10] = '{1'b0, 5'h1C, 32'h0,         32'h0, 1'b1, 32'hFFFF, 32'h0A00_0F0F};
    vecs[11] = '{1'b0, 5'h14, 32'h0,         32'h0, 1'b1, 32'hFFFF, 32'h0A00_0F0F};
    vecs[12] = '{1'b0, 5'h07, 32'h0,         32'h0A00_0F0F, 1'b0, 32'hFFFF, 32'h0A00_0F0F};
    vecs[13] = '{1'b0, 5'h10, 32'h0,         32'h0, 1'b0, 32'hFFFF, 32'h0A00_0F0F};

    // Clock/reset
    repeat (2) @(negedge clk);
    check("rst_ready", {31'd0, ready}, 32'd1);
    check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    check("rst_dir", dir, 32'h0);
    check("rst_out", out, 32'h0);
    check("rst_pulses", set_p | clr_p, 32'h0);
    rst = 1'b0;
    @(negedge clk);

    // Register table
    for (int i = 0; i < 14; i++) begin
      issue(vecs[i].we, vecs[i].addr, vecs[i].wdata, 4'hF);
      check($sformatf("v%0d_valid", i), {31'd0, resp_valid}, 32'd1);
      check($sformatf("v%0d_rdata", i), rdata, vecs[i].exp_rdata);
      check($sformatf("v%0d_err", i), {31'd0, err}, {31'd0, vecs[i].exp_err});
      check($sformatf("v%0d_dir", i), dir, vecs[i].exp_dir);
      check($sformatf("v%0d_out", i), out, vecs[i].exp_out);
      finish_resp();
    end

    // Set/clear pulses last exactly one cycle and OUT keeps the result
    issue(1'b1, 5'h04, 32'h0000_00F0, 4'hF);
    finish_resp();
    issue(1'b1, 5'h08, 32'h0000_000F, 4'hF);
    check("set_pulse", set_p, 32'h0000_000F);
    check("set_no_clr", clr_p, 32'h0);
    check("set_out", out, 32'h0000_00FF);
    finish_resp();
    check("set_pulse_end", set_p, 32'h0);
    issue(1'b1, 5'h0C, 32'h0000_00F0, 4'hF);
    check("clr_pulse", clr_p, 32'h0000_00F0);
    check("clr_no_set", set_p, 32'h0);
    check("clr_out", out, 32'h0000_000F);
    finish_resp();
    check("clr_pulse_end", clr_p, 32'h0);
    check("clr_out_persist", out, 32'h0000_000F);

    // Back-pressure: response held, competing request ignored
    issue(1'b0, 5'h04, 32'h0, 4'hF);
    req = 1'b1; we = 1'b1; addr = 5'h04; wdata = 32'hDEAD_BEEF;
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", {31'd0, resp_valid}, 32'd1);
      check("bp_ready", {31'd0, ready}, 32'd0);
      check("bp_rdata", rdata, 32'h0000_000F);
      @(posedge clk);
      #1;
    end
    req = 1'b0;
    finish_resp();
    check("bp_out_unchanged", out, 32'h0000_000F);
    check("bp_ready_back", {31'd0, ready}, 32'd1);

    // Input synchroniser latency
    issue(1'b0, 5'h00, 32'h0, 4'hF);
    gpio_in = 32'h1234_5678;
    finish_resp();
    issue(1'b0, 5'h10, 32'h0, 4'hF);
    check("sync_early", rdata, 32'h0);
    finish_resp();
    issue(1'b0, 5'h10, 32'h0, 4'hF);
    check("sync_late", rdata, 32'h1234_5678);
    finish_resp();

    // Asynchronous reset in the middle of a response
    issue(1'b1, 5'h00, 32'h0000_00FF, 4'hF);
    #2;
    rst = 1'b1;
    #1;
    check("arst_valid", {31'd0, resp_valid}, 32'd0);
    check("arst_ready", {31'd0, ready}, 32'd1);
    check("arst_dir", dir, 32'h0);
    check("arst_out", out, 32'h0);
    check("arst_rdata", rdata, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    issue(1'b0, 5'h00, 32'h0, 4'hF);
    check("arst_dir_read", rdata, 32'h0);
    finish_resp();

`ifdef GPIO_BYTE_STROBE_EN
    issue(1'b1, 5'h00, 32'hFFFF_FFFF, 4'b0010);
    check("be_dir", dir, 32'h0000_FF00);
    check("be_err", {31'd0, err}, 32'd0);
    finish_resp();
    issue(1'b1, 5'h04, 32'hFFFF_FFFF, 4'b0000);
    check("be0_out", out, 32'h0);
    check("be0_err", {31'd0, err}, 32'd0);
    finish_resp();
    issue(1'b1, 5'h08, 32'hFFFF_FFFF, 4'b1000);
    check("be_set_pulse", set_p, 32'hFF00_0000);
    check("be_set_out", out, 32'hFF00_0000);
    finish_resp();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/gpio_reg_if.md
Name: gpio_reg_if

Overview:
Bus-slave register front end for the GPIO block. It sits directly upstream of the GPIO output stage and drives that stage's direction, output, set and clear vectors. It decodes single-outstanding req/resp bus accesses into GPIO control registers. It also synchronises the raw GPIO input pins for read-back.

Parameters:
GPIO_WIDTH, 32, number of GPIO lines.
ADDR_W, 5, byte-address width of the register window.
SYNC_STAGES, 2, flop stages on the input synchroniser (minimum 2).

Ports:
clk_i  input  1  clock.
rst_i  input  1  reset, asynchronous, active-high.
req_i  input  1  bus request valid.
ready_o  output  1  request accepted this cycle when req_i & ready_o.
we_i  input  1  1 = write, 0 = read.
addr_i  input  ADDR_W  byte address; bits [1:0] ignored.
wdata_i  input  32  write data.
be_i  input  4  byte enables (used only with GPIO_BYTE_STROBE_EN).
resp_valid_o  output  1  response valid.
resp_ready_i  input  1  requester accepts response.
rdata_o  output  32  read data; 0 for writes and errors.
err_o  output  1  access error, qualified by resp_valid_o.
gpio_input_i  input  GPIO_WIDTH  raw asynchronous pin inputs.
gpio_direction_o  output  GPIO_WIDTH  DIR register, 1 = output.
gpio_output_o  output  GPIO_WIDTH  OUT register.
gpio_output_set_o  output  GPIO_WIDTH  one-cycle set pulse.
gpio_output_clr_o  output  GPIO_WIDTH  one-cycle clear pulse.

Behaviour:
- Register map, word offsets:
  - 0x00 DIR: RW.
  - 0x04 OUT: RW.
  - 0x08 SET: WO, reads 0.
  - 0x0C CLR: WO, reads 0.
  - 0x10 IN: RO, returns synchronised pins.
  - Any other address: err_o=1.
- State machine:
  - IDLE: ready_o=1, resp_valid_o=0.
  - IDLE -> RESP on req_i (the request is accepted at that edge).
  - RESP: ready_o=0, resp_valid_o=1.
  - RESP -> IDLE when resp_ready_i=1. RESP holds while resp_ready_i=0.
  - Minimum access period is 2 cycles. Only one access is outstanding at a time.
- rdata_o and err_o are captured at the accept edge and held stable for the whole RESP state.
- Writes take effect at the accept edge:
  - DIR and OUT are loaded directly.
  - SET: OUT <= OUT | wdata, and gpio_output_set_o <= wdata for exactly one cycle, then 0.
  - CLR: OUT <= OUT & ~wdata, and gpio_output_clr_o <= wdata for exactly one cycle, then 0.
  - The pulses plus the OUT update keep the downstream output stage's result persistent after the pulse ends.
  - Set and clear pulses are never asserted in the same cycle.
- Error cases:
  - A write to IN or to an unmapped address changes no state and returns err_o=1.
  - A read of SET or CLR returns 0 with err_o=0.
- Input synchroniser:
  - SYNC_STAGES-deep flop chain, reset to 0.
  - A pin change is readable via IN no earlier than SYNC_STAGES edges later.
- Width rules:
  - When GPIO_WIDTH < 32, write data is truncated and read data is zero-extended.
  - GPIO_WIDTH > 32 is unsupported.
- Reset, asynchronous:
  - State = IDLE; ready_o=1; resp_valid_o=0; rdata_o=0; err_o=0.
  - DIR=0, OUT=0, both pulses=0, synchroniser=0.
  - Reset during RESP drops the response with no completion. The requester must reissue.

Optional Feature:
Macro GPIO_BYTE_STROBE_EN.
- Defined:
  - Writes to DIR and OUT update only bytes with be_i[n]=1.
  - SET and CLR mask wdata by the expanded be_i before updating OUT and forming the pulse.
  - be_i=0 is a legal no-op write with err_o=0.
- Undefined: be_i is ignored and every write is full-word.

Decomposition:
- Package gpio_pkg holds:
  - Register offset constants: GPIO_DIR_OFS, GPIO_OUT_OFS, GPIO_SET_OFS, GPIO_CLR_OFS, GPIO_IN_OFS.
  - The bus-state enum: IDLE, RESP.
  - The default GPIO_WIDTH.
- One sub-module, gpio_sync: parameterised SYNC_STAGES flop chain for the input pins.

Test Plan:
- Reset: assert rst_i mid-RESP -> resp_valid_o=0, ready_o=1, DIR=0, OUT=0 immediately, with no clock edge needed.
- Write then read OUT: write OUT=0xA5A5_0F0F -> resp_valid_o=1 next cycle with err_o=0; read 0x04 -> rdata_o=0xA5A5_0F0F.
- Set/clear pulses: OUT=0x0000_00F0; write SET=0x0000_000F -> set pulse=0x0000_000F for 1 cycle, OUT=0x0000_00FF; write CLR=0x0000_00F0 -> clr pulse for 1 cycle, OUT=0x0000_000F.
- Back-pressure: hold resp_ready_i=0 for 5 cycles -> resp_valid_o and rdata_o stable, ready_o=0; new req_i ignored until return to IDLE.
- Input sync: gpio_input_i=0x1234_5678 -> IN read reflects it only after 2 edges; an earlier read returns the old value.
- Errors: write to 0x10 or 0x1C -> err_o=1, no register change; with GPIO_BYTE_STROBE_EN, write DIR=0xFFFF_FFFF with be_i=0b0010 -> DIR=0x0000_FF00.
